mips_multicycle_control: RTL and testbench

Multicycle main control FSM for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives all datapath enables and muxes. Generates the 2-bit `ALUOp` consumed by the ALU control unit, which combines it with `Funct` to produce the 4-bit ALU operation. Supports R-type, LW, SW, BEQ, BNE and optional J, and stalls on a memory-ready handshake.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mips_mc_output_decode.sv | 60 ++++++
 rtl/mips_multicycle_control.sv | 84 ++++++++
 tb/tb_mips_multicycle_control.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, state, select encodings and control word for the multicycle MIPS control
package mips_pkg;
  typedef enum logic [5:0] {
    OP_R   = 6'b000000,
    OP_J   = 6'b000010,
    OP_BEQ = 6'b000100,
    OP_BNE = 6'b000101,
    OP_LW  = 6'b100011,
    OP_SW  = 6'b101011
  } opcode_t;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;
  typedef enum logic [2:0] {CLS_NONE, CLS_R, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J} cls_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} aluop_t;
  typedef enum logic [1:0] {SRCB_B, SRCB_4, SRCB_IMM, SRCB_IMM_SH2} srcb_t;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP} pcsrc_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
  function automatic cls_t op_class(input logic [5:0] op);
    case (op)
      OP_R:   return CLS_R;
      OP_LW:  return CLS_LW;
      OP_SW:  return CLS_SW;
      OP_BEQ: return CLS_BEQ;
      OP_BNE: return CLS_BNE;
`ifdef MIPS_MC_JUMP_EN
      OP_J:   return CLS_J;
`else
      OP_J:   return CLS_NONE;
`endif
      default: return CLS_NONE;
    endcase
  endfunction
endpackage

// File: rtl/mips_mc_output_decode.sv
// mips_mc_output_decode: state to control-word decode; JUMP decode only with MIPS_MC_JUMP_EN
module mips_mc_output_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   bne,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
        ctrl.alu_src_b = SRCB_4;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source = PC_ALUOUT;
        ctrl.branch_ne = bne;
      end
`ifdef MIPS_MC_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
`endif
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM; J support with MIPS_MC_JUMP_EN
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp
);
  state_t state, next;
  cls_t   cls, dec_cls;
  ctrl_t  ctrl, q;
  logic   run;
  assign dec_cls = op_class(Opcode);
  // run holds outputs quiet during reset and for the first cycle after release
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_FETCH;
      cls <= CLS_NONE;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      state <= next;
      if (state == S_DECODE) cls <= dec_cls;
    end
  always_comb begin
    next = state;
    if (!run) next = S_FETCH;
    else case (state)
      S_FETCH:  next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: case (dec_cls)
        CLS_LW, CLS_SW:   next = S_MEMADR;
        CLS_R:            next = S_EXEC;
        CLS_BEQ, CLS_BNE: next = S_BRANCH;
`ifdef MIPS_MC_JUMP_EN
        CLS_J:            next = S_JUMP;
`endif
        default:          next = S_FETCH;
      endcase
      S_MEMADR: next = (cls == CLS_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   next = S_RWB;
      default:  next = S_FETCH;
    endcase
  end
  mips_mc_output_decode u_dec (
    .state     (state),
    .bne       (cls == CLS_BNE),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );
  assign q = run ? ctrl : '0;
  assign IllegalOp = run && state == S_DECODE && dec_cls == CLS_NONE;
  assign PCWrite = q.pc_write;
  assign PCWriteCond = q.pc_write_cond;
  assign BranchNE = q.branch_ne;
  assign IorD = q.iord;
  assign MemRead = q.mem_read;
  assign MemWrite = q.mem_write;
  assign IRWrite = q.ir_write;
  assign MemtoReg = q.mem_to_reg;
  assign RegDst = q.reg_dst;
  assign RegWrite = q.reg_write;
  assign ALUSrcA = q.alu_src_a;
  assign ALUSrcB = q.alu_src_b;
  assign ALUOp = q.alu_op;
  assign PCSource = q.pc_source;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: scoreboard bench for the multicycle control FSM
module tb_mips_multicycle_control;
  import mips_pkg::*;
  logic clk = 1'b0, reset = 1'b1, MemReady = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [21:0] expq[$], obsq[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp)
  );
  // expected {state, control word} straight from the state output table
  function automatic logic [21:0] ex(input int st, input bit bne, input bit mr, input bit ill);
    logic pw, pwc, bn, iord, mrd, mwr, irw, m2r, rd, rw, sa;
    logic [1:0] sb, op, ps;
    {pw, pwc, bn, iord, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      0: begin pw = mr; irw = mr; mrd = 1; sb = 2'b01; end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin sa = 1; op = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; bn = bne; end
      9: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {4'(st), pw, pwc, bn, iord, mrd, mwr, irw, m2r, rd, rw, sa, sb, op, ps, ill};
  endfunction
  task automatic drive(input logic mr, input logic [5:0] op);
    MemReady = mr;
    Opcode = op;
    @(negedge clk);
    obsq.push_back({4'(dut.state), PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
                    IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp});
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [21:0] e, o;
    int n = 0;
    expq.push_back(22'd0); drive(1, OP_SW);
    reset = 0;
    expq.push_back(22'd0); drive(1, OP_SW);
    expq.push_back(ex(0, 0, 1, 0)); drive(1, OP_SW);
    expq.push_back(ex(1, 0, 1, 0)); drive(1, OP_SW);
    expq.push_back(ex(2, 0, 1, 0)); drive(1, OP_SW);
    expq.push_back(ex(5, 0, 0, 0)); drive(0, OP_SW);
    reset = 1;
    expq.push_back(22'd0); drive(0, OP_SW);
    reset = 0;
    expq.push_back(22'd0); drive(1, OP_SW);
    while (expq.size() != 0) begin
      e = expq.pop_front();
      o = (obsq.size() != 0) ? obsq.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset[%0d] got state=%0d ctrl=%h want state=%0d ctrl=%h", n, o[21:18], o[17:0], e[21:18], e[17:0]);
      end
      n++;
    end
  endtask
  task automatic test_rtype();
    logic [21:0] e, o;
    int n = 0;
    expq.push_back(ex(0, 0, 1, 0)); drive(1, OP_R);
    expq.push_back(ex(1, 0, 1, 0)); drive(1, OP_R);
    expq.push_back(ex(6, 0, 0, 0)); drive(0, OP_R);
    expq.push_back(ex(7, 0, 0, 0)); drive(0, OP_R);
    while (expq.size() != 0) begin
      e = expq.pop_front();
      o = (obsq.size() != 0) ? obsq.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rtype[%0d] got state=%0d ctrl=%h want state=%0d ctrl=%h", n, o[21:18], o[17:0], e[21:18], e[17:0]);
      end
      n++;
    end
  endtask
  task automatic test_lw_stall();
    logic [21:0] e, o;
    int n = 0;
    expq.push_back(ex(0, 0, 0, 0)); drive(0, OP_LW);
    expq.push_back(ex(0, 0, 1, 0)); drive(1, OP_LW);
    expq.push_back(ex(1, 0, 1, 0)); drive(1, OP_LW);
    expq.push_back(ex(2, 0, 1, 0)); drive(1, OP_LW);
    expq.push_back(ex(3, 0, 0, 0)); drive(0, OP_LW);
    expq.push_back(ex(3, 0, 0, 0)); drive(0, OP_LW);
    expq.push_back(ex(3, 0, 1, 0)); drive(1, OP_LW);
    expq.push_back(ex(4, 0, 1, 0)); drive(1, OP_LW);
    while (expq.size() != 0) begin
      e = expq.pop_front();
      o = (obsq.size() != 0) ? obsq.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL lw[%0d] got state=%0d ctrl=%h want state=%0d ctrl=%h", n, o[21:18], o[17:0], e[21:18], e[17:0]);
      end
      n++;
    end
  endtask
  task automatic test_branch();
    logic [21:0] e, o;
    int n = 0;
    expq.push_back(ex(0, 0, 1, 0)); drive(1, OP_BNE);
    expq.push_back(ex(1, 0, 1, 0)); drive(1, OP_BNE);
    expq.push_back(ex(8, 1, 1, 0)); drive(1, OP_R);
    expq.push_back(ex(0, 0, 1, 0)); drive(1, OP_BEQ);
    expq.push_back(ex(1, 0, 1, 0)); drive(1, OP_BEQ);
    expq.push_back(ex(8, 0, 1, 0)); drive(1, OP_BNE);
    while (expq.size() != 0) begin
      e = expq.pop_front();
      o = (obsq.size() != 0) ? obsq.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL branch[%0d] got state=%0d ctrl=%h want state=%0d ctrl=%h", n, o[21:18], o[17:0], e[21:18], e[17:0]);
      end
      n++;
    end
  endtask
  task automatic test_illegal();
    logic [21:0] e, o;
    int n = 0;
    expq.push_back(ex(0, 0, 1, 0)); drive(1, 6'h3f);
    expq.push_back(ex(1, 0, 1, 1)); drive(1, 6'h3f);
    expq.push_back(ex(0, 0, 0, 0)); drive(0, 6'h3f);
    while (expq.size() != 0) begin
      e = expq.pop_front();
      o = (obsq.size() != 0) ? obsq.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL illegal[%0d] got state=%0d ctrl=%h want state=%0d ctrl=%h", n, o[21:18], o[17:0], e[21:18], e[17:0]);
      end
      n++;
    end
  endtask
  task automatic test_jump();
    logic [21:0] e, o;
    int n = 0;
    expq.push_back(ex(0, 0, 1, 0)); drive(1, OP_J);
`ifdef MIPS_MC_JUMP_EN
    expq.push_back(ex(1, 0, 1, 0)); drive(1, OP_J);
    expq.push_back(ex(9, 0, 1, 0)); drive(1, OP_J);
`else
    expq.push_back(ex(1, 0, 1, 1)); drive(1, OP_J);
`endif
    expq.push_back(ex(0, 0, 0, 0)); drive(0, OP_J);
    while (expq.size() != 0) begin
      e = expq.pop_front();
      o = (obsq.size() != 0) ? obsq.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL jump[%0d] got state=%0d ctrl=%h want state=%0d ctrl=%h", n, o[21:18], o[17:0], e[21:18], e[17:0]);
      end
      n++;
    end
  endtask
  task automatic test_back_to_back();
    logic [21:0] e, o;
    int n = 0;
    expq.push_back(ex(0, 0, 1, 0)); drive(1, OP_SW);
    expq.push_back(ex(1, 0, 1, 0)); drive(1, OP_SW);
    expq.push_back(ex(2, 0, 1, 0)); drive(1, OP_SW);
    expq.push_back(ex(5, 0, 1, 0)); drive(1, OP_SW);
    expq.push_back(ex(0, 0, 1, 0)); drive(1, OP_R);
    expq.push_back(ex(1, 0, 1, 0)); drive(1, OP_R);
    expq.push_back(ex(6, 0, 1, 0)); drive(1, OP_R);
    expq.push_back(ex(7, 0, 1, 0)); drive(1, OP_R);
    expq.push_back(ex(0, 0, 0, 0)); drive(0, OP_R);
    while (expq.size() != 0) begin
      e = expq.pop_front();
      o = (obsq.size() != 0) ? obsq.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL b2b[%0d] got state=%0d ctrl=%h want state=%0d ctrl=%h", n, o[21:18], o[17:0], e[21:18], e[17:0]);
      end
      n++;
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_jump();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
